// File: rtl/npc_predictor_pkg.sv
// Shared definitions for the next-PC predictor.
//   WORDSIZE  - datapath / PC width
//   PCBASE    - PC value the downstream PC register loads on reset
//   BTB_IDX_W - default log2 of BTB entry count
//   ctr_e     - 2-bit saturating direction counter encodings
//   ctr_step  - saturating counter update helper
package npc_predictor_pkg;

    localparam int unsigned WORDSIZE  = 32;
    localparam logic [31:0] PCBASE    = 32'hBFC0_0000;
    localparam int unsigned BTB_IDX_W = 4;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
        ctr_e nxt;
        nxt = cur;
        if (taken) begin
            if (cur != ST) nxt = ctr_e'(cur + 2'b01);
        end else begin
            if (cur != SNT) nxt = ctr_e'(cur - 2'b01);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/npc_predictor_btb_ram.sv
// Direct-mapped BTB storage.
//   Two asynchronous read ports (fetch lookup, EX update lookup),
//   one synchronous write port, asynchronous clear on rst.
//   Cleared state: valid=0, ctr=WNT, tag=0, tgt=0.
module btb_ram
    import npc_predictor_pkg::*;
#(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned TAG_W = 26
) (
    input  logic             clk,
    input  logic             rst,
    // fetch-side read port
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output ctr_e             rd_ctr,
    output logic [31:0]      rd_tgt,
    // update-side read port
    input  logic [IDX_W-1:0] up_idx,
    output logic             up_valid,
    output logic [TAG_W-1:0] up_tag,
    output ctr_e             up_ctr,
    output logic [31:0]      up_tgt,
    // write port (always writes a valid entry)
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  ctr_e             wr_ctr,
    input  logic [31:0]      wr_tgt
);
    localparam int unsigned DEPTH = 1 << IDX_W;

    logic             valid_q [DEPTH];
    logic [TAG_W-1:0] tag_q   [DEPTH];
    ctr_e             ctr_q   [DEPTH];
    logic [31:0]      tgt_q   [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= WNT;
                tgt_q[i]   <= '0;
            end
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            ctr_q[wr_idx]   <= wr_ctr;
            tgt_q[wr_idx]   <= wr_tgt;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_ctr   = ctr_q[rd_idx];
    assign rd_tgt   = tgt_q[rd_idx];

    assign up_valid = valid_q[up_idx];
    assign up_tag   = tag_q[up_idx];
    assign up_ctr   = ctr_q[up_idx];
    assign up_tgt   = tgt_q[up_idx];

endmodule

// File: rtl/npc_predictor.sv
// Next-PC generator feeding the PC register.
//   Predicts with a direct-mapped BTB + 2-bit counters, redirects on an EX
//   mispredict, and keeps resolved-branch / mispredict perf counters.
// Ports:
//   clk, rst                      clock, async active-high reset
//   pcF, installF                 fetch PC and fetch stall
//   npc                           next PC to the PC register
//   pred_takenF, pred_targetF     prediction carried with the fetched instr
//   res_*                         EX-stage branch resolution
//   mispredictE                   redirect / flush request
//   br_count, mis_count           perf counters (wrap at 2^32)
module npc_predictor
    import npc_predictor_pkg::*;
#(
    parameter int unsigned BTB_IDX_W = npc_predictor_pkg::BTB_IDX_W,
    parameter logic [31:0] PC_RESET  = PCBASE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic        installF,
    output logic [31:0] npc,
    output logic        pred_takenF,
    output logic [31:0] pred_targetF,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_tgt,
    output logic        mispredictE,
    output logic [31:0] br_count,
    output logic [31:0] mis_count
);
    localparam int unsigned TAG_W = WORDSIZE - BTB_IDX_W - 2;

    logic [BTB_IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0]     tag_f, tag_e;

    logic                 rd_valid, up_valid;
    logic [TAG_W-1:0]     rd_tag, up_tag;
    ctr_e                 rd_ctr, up_ctr;
    logic [31:0]          rd_tgt, up_tgt;

    logic                 hit_f, hit_e;
    logic [31:0]          pc_plus4, actual_next;
    logic                 wr_en;
    ctr_e                 wr_ctr;
    logic [31:0]          wr_tgt;

    assign idx_f = pcF[BTB_IDX_W+1:2];
    assign tag_f = pcF[31:BTB_IDX_W+2];
    assign idx_e = res_pc[BTB_IDX_W+1:2];
    assign tag_e = res_pc[31:BTB_IDX_W+2];

    btb_ram #(
        .IDX_W (BTB_IDX_W),
        .TAG_W (TAG_W)
    ) u_btb (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (idx_f),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_ctr   (rd_ctr),
        .rd_tgt   (rd_tgt),
        .up_idx   (idx_e),
        .up_valid (up_valid),
        .up_tag   (up_tag),
        .up_ctr   (up_ctr),
        .up_tgt   (up_tgt),
        .wr_en    (wr_en),
        .wr_idx   (idx_e),
        .wr_tag   (tag_e),
        .wr_ctr   (wr_ctr),
        .wr_tgt   (wr_tgt)
    );

    // Fetch-side lookup; reads pre-update contents (no write bypass).
    assign hit_f        = rd_valid && (rd_tag == tag_f);
    assign pc_plus4     = pcF + 32'd4;
    assign pred_takenF  = hit_f && rd_ctr[1];
    assign pred_targetF = pred_takenF ? rd_tgt : pc_plus4;

    // Comparing against the piped predicted target catches both direction
    // and target errors; res_pred_taken is carried only for visibility.
    assign actual_next = res_taken ? res_target : (res_pc + 32'd4);
    assign mispredictE = res_valid && (actual_next != res_pred_tgt);

    always_comb begin
        npc = pred_targetF;
        if (mispredictE)   npc = actual_next;
        else if (installF) npc = pcF;
    end

    // Update: hits train the counter, taken misses allocate, not-taken
    // misses leave the table alone. Target only changes on taken.
    assign hit_e  = up_valid && (up_tag == tag_e);
    assign wr_en  = res_valid && (hit_e || res_taken);
    assign wr_ctr = hit_e ? ctr_step(up_ctr, res_taken) : WT;
    assign wr_tgt = res_taken ? res_target : up_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            br_count  <= br_count + {31'd0, res_valid};
            mis_count <= mis_count + {31'd0, mispredictE};
        end
    end

endmodule

// File: tb/tb_npc_predictor.sv
// Self-checking bench for npc_predictor: a stateful vector table applied
// through an expectation queue, plus hand sequences for reset and counters.
module tb_npc_predictor;
    import npc_predictor_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pcF = 32'h0;
    logic        installF = 1'b0;
    logic [31:0] npc;
    logic        pred_takenF;
    logic [31:0] pred_targetF;
    logic        res_valid = 1'b0;
    logic [31:0] res_pc = 32'h0;
    logic        res_taken = 1'b0;
    logic [31:0] res_target = 32'h0;
    logic        res_pred_taken = 1'b0;
    logic [31:0] res_pred_tgt = 32'h0;
    logic        mispredictE;
    logic [31:0] br_count;
    logic [31:0] mis_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    npc_predictor dut (
        .clk            (clk),
        .rst            (rst),
        .pcF            (pcF),
        .installF       (installF),
        .npc            (npc),
        .pred_takenF    (pred_takenF),
        .pred_targetF   (pred_targetF),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_taken      (res_taken),
        .res_target     (res_target),
        .res_pred_taken (res_pred_taken),
        .res_pred_tgt   (res_pred_tgt),
        .mispredictE    (mispredictE),
        .br_count       (br_count),
        .mis_count      (mis_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        rtk;
        logic [31:0] rtgt;
        logic        rptk;
        logic [31:0] rptgt;
        logic [31:0] e_npc;
        logic        e_pt;
        logic        e_mis;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] e_npc;
        logic        e_pt;
        logic        e_mis;
        logic [31:0] e_br;
        logic [31:0] e_misc;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    logic [31:0] m_br = 0;
    logic [31:0] m_mis = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s[%0d]: got 0x%08h want 0x%08h", name, id, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        pcF            = v.pc;
        installF       = v.stall;
        res_valid      = v.rv;
        res_pc         = v.rpc;
        res_taken      = v.rtk;
        res_target     = v.rtgt;
        res_pred_taken = v.rptk;
        res_pred_tgt   = v.rptgt;
    endtask

    task automatic apply(input int id, input vec_t v);
        exp_t e;
        @(posedge clk);
        #1;
        drive(v);
        e.id = id; e.e_npc = v.e_npc; e.e_pt = v.e_pt; e.e_mis = v.e_mis;
        e.e_br = m_br; e.e_misc = m_mis;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        chk("npc", e.id, npc, e.e_npc);
        chk("pred_taken", e.id, {31'd0, pred_takenF}, {31'd0, e.e_pt});
        chk("mispredict", e.id, {31'd0, mispredictE}, {31'd0, e.e_mis});
        chk("br_count", e.id, br_count, e.e_br);
        chk("mis_count", e.id, mis_count, e.e_misc);
        // model the coming posedge
        m_br  = m_br + {31'd0, v.rv};
        m_mis = m_mis + {31'd0, v.e_mis};
    endtask

    function automatic vec_t mk(input logic [31:0] pc, input logic stall, input logic rv,
                                input logic [31:0] rpc, input logic rtk, input logic [31:0] rtgt,
                                input logic [31:0] rptgt, input logic [31:0] e_npc,
                                input logic e_pt, input logic e_mis);
        vec_t v;
        v.pc = pc; v.stall = stall; v.rv = rv; v.rpc = rpc; v.rtk = rtk; v.rtgt = rtgt;
        v.rptk = (rptgt != rpc + 32'd4); v.rptgt = rptgt;
        v.e_npc = e_npc; v.e_pt = e_pt; v.e_mis = e_mis;
        return v;
    endfunction

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        //              pcF           stl rv  res_pc        tk  target     pred_tgt     exp npc      pt mis
        vecs.push_back(mk(32'hBFC00000,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'hBFC00004,0, 0));
        vecs.push_back(mk(32'h00000000,0, 1, 32'h100,       1, 32'h200,   32'h104,     32'h200,     0, 1));
        vecs.push_back(mk(32'h00000100,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'h200,     1, 0));
        vecs.push_back(mk(32'h00000100,0, 1, 32'h100,       0, 32'h0,     32'h200,     32'h104,     1, 1));
        vecs.push_back(mk(32'h00000100,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'h104,     0, 0));
        vecs.push_back(mk(32'h00000100,0, 1, 32'h100,       1, 32'h200,   32'h104,     32'h200,     0, 1));
        vecs.push_back(mk(32'h00000100,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'h200,     1, 0));
        vecs.push_back(mk(32'h00000300,1, 0, 32'h0,         0, 32'h0,     32'h4,       32'h300,     0, 0));
        vecs.push_back(mk(32'h00000300,1, 1, 32'h388,       1, 32'h400,   32'h38C,     32'h400,     0, 1));
        vecs.push_back(mk(32'h00000104,0, 1, 32'h100,       1, 32'h200,   32'h200,     32'h108,     0, 0));
        vecs.push_back(mk(32'h00000100,0, 1, 32'h140,       1, 32'h500,   32'h144,     32'h500,     1, 1));
        vecs.push_back(mk(32'h00000100,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'h104,     0, 0));
        vecs.push_back(mk(32'h00000140,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'h500,     1, 0));
        vecs.push_back(mk(32'h00001000,0, 1, 32'h1000,      0, 32'h0,     32'h1004,    32'h1004,    0, 0));
        vecs.push_back(mk(32'h00001000,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'h1004,    0, 0));
        vecs.push_back(mk(32'h00000388,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'h400,     1, 0));
        vecs.push_back(mk(32'hFFFFFFFC,0, 0, 32'h0,         0, 32'h0,     32'h4,       32'h00000000,0, 0));

        // reset state observed while rst is held
        pcF = PCBASE;
        #12;
        chk("rst_npc", -1, npc, 32'hBFC00004);
        chk("rst_pred_taken", -1, {31'd0, pred_takenF}, 32'd0);
        chk("rst_br_count", -1, br_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // counters: 5 resolves, 2 mispredicted, starting from a fresh reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_br_count", -2, br_count, 32'd0);
        rst = 1'b0;
        m_br = 0; m_mis = 0;
        apply(100, mk(32'h0, 0, 1, 32'h2000, 0, 32'h0,    32'h2004, 32'h4,    0, 0));
        apply(101, mk(32'h0, 0, 1, 32'h3000, 1, 32'h3100, 32'h3004, 32'h3100, 0, 1));
        apply(102, mk(32'h0, 0, 1, 32'h2000, 0, 32'h0,    32'h2004, 32'h4,    0, 0));
        apply(103, mk(32'h0, 0, 1, 32'h3000, 1, 32'h3100, 32'h3004, 32'h3100, 0, 1));
        apply(104, mk(32'h0, 0, 1, 32'h2000, 0, 32'h0,    32'h2004, 32'h4,    0, 0));
        @(posedge clk);
        #1;
        drive(mk(32'h3000, 0, 0, 32'h0, 0, 32'h0, 32'h4, 32'h0, 0, 0));
        #1;
        chk("br_count_5", 105, br_count, 32'd5);
        chk("mis_count_2", 105, mis_count, 32'd2);
        chk("learned_pt", 105, {31'd0, pred_takenF}, 32'd1);
        chk("learned_npc", 105, npc, 32'h3100);

        // async reset mid-cycle: counters and BTB clear with no clock edge,
        // and a resolve in flight at that moment is dropped
        drive(mk(32'h3000, 0, 1, 32'h2000, 1, 32'h2400, 32'h2004, 32'h0, 0, 0));
        #1;
        rst = 1'b1;
        #1;
        chk("async_br_count", 106, br_count, 32'd0);
        chk("async_mis_count", 106, mis_count, 32'd0);
        chk("async_pred_taken", 106, {31'd0, pred_takenF}, 32'd0);
        @(posedge clk);
        #1;
        drive(mk(32'h2000, 0, 0, 32'h0, 0, 32'h0, 32'h4, 32'h0, 0, 0));
        rst = 1'b0;
        #1;
        chk("dropped_update_pt", 107, {31'd0, pred_takenF}, 32'd0);
        chk("dropped_update_npc", 107, npc, 32'h2004);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
